// File: rtl/pipeline_branch_unit_pkg.sv
// Shared definitions for the MEM-stage branch resolution unit:
// branch condition codes, BHT counter states and the counter update rule.
package pipeline_branch_unit_pkg;

    // funct3 encodings of the conditional branches.
    // The values 010 and 011 are not branches and never evaluate as taken.
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    // 2-bit saturating counter states. Bit 1 is the taken prediction.
    localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

    // Every history entry starts out weakly not-taken.
    localparam logic [1:0] BHT_RESET = CNT_WNT;

    // Moves a counter one step toward the resolved outcome, saturating at the ends.
    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/pipeline_branch_unit_branch_cond_eval.sv
// Combinational branch condition evaluator: maps funct3 and the ALU
// comparison flags to a single "condition holds" bit.
module branch_cond_eval
    import pipeline_branch_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       cond
);

    // Select the flag (or its inverse) named by funct3; unused codes give 0.
    always_comb begin
        // NOTE: cond gets a default before the case so that no path leaves it
        // unassigned, which would otherwise infer a latch.
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = ~zero;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = ~lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipeline_branch_unit.sv
// MEM-stage branch resolution unit. Resolves conditional branches and
// jumps, issues a one-cycle redirect/flush on a mispredict, trains a
// bimodal branch history table used for fetch-stage prediction, and keeps
// saturating counts of resolved control transfers and mispredicts.
module pipeline_branch_unit
    import pipeline_branch_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic [XLEN-1:0] pc_if,
    output logic            pred_taken_if,

    input  logic            valid_in_Mem,
    input  logic [XLEN-1:0] pc_in_Mem,
    input  logic [XLEN-1:0] target_in_Mem,
    input  logic            Branch_in_Mem,
    input  logic            Jump_in_Mem,
    input  logic [2:0]      funct3_in_Mem,
    input  logic            zero_in_Mem,
    input  logic            lt_in_Mem,
    input  logic            ltu_in_Mem,
    input  logic            pred_taken_in_Mem,

    output logic            PCSrc,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,

    input  logic            stat_clr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             cond;
    logic             resolve;
    logic             taken;
    logic             mispredict;
    logic [XLEN-1:0]  fallthrough_pc;
    logic [XLEN-1:0]  next_redirect;
    logic             unused_pc_bits;

    branch_cond_eval u_cond (
        .funct3 (funct3_in_Mem),
        .zero   (zero_in_Mem),
        .lt     (lt_in_Mem),
        .ltu    (ltu_in_Mem),
        .cond   (cond)
    );

    // Word-aligned PC bits select the history entry; higher bits alias.
    assign if_idx  = pc_if[IDX_W+1:2];
    assign mem_idx = pc_in_Mem[IDX_W+1:2];

    // Bits of the fetch PC that play no part in the lookup.
    assign unused_pc_bits = ^{pc_if[XLEN-1:IDX_W+2], pc_if[1:0]};

    // Fetch prediction reads the stored counter directly: an update landing
    // on the same entry this cycle is seen only from the next cycle on.
    assign pred_taken_if = bht[if_idx][1];

    // Resolve the MEM-stage instruction; a wrong-path instruction sitting in
    // MEM during a flush cycle is ignored completely.
    always_comb begin
        resolve        = valid_in_Mem & (Branch_in_Mem | Jump_in_Mem) & ~flush;
        taken          = Jump_in_Mem | (Branch_in_Mem & cond);
        mispredict     = resolve & (taken != pred_taken_in_Mem);
        fallthrough_pc = pc_in_Mem + XLEN'(4);
        next_redirect  = taken ? target_in_Mem : fallthrough_pc;
    end

    // Redirect and flush pulse for one cycle after a mispredict; the redirect
    // address holds its last value between mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            PCSrc       <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            PCSrc <= mispredict;
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= next_redirect;
            end
        end
    end

    // Train the history table on resolved conditional branches only.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the table is built from flops rather than a RAM macro because
        // every entry must return to weakly not-taken on reset.
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= BHT_RESET;
            end
        end else if (resolve && Branch_in_Mem) begin
            bht[mem_idx] <= bht_next(bht[mem_idx], taken);
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else if (stat_clr) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (resolve && (br_cnt != {CNT_W{1'b1}})) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (mispredict && (mis_cnt != {CNT_W{1'b1}})) begin
                mis_cnt <= mis_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_branch_unit.md
PIPELINE_BRANCH_UNIT -- requirements
Module: pipeline_branch_unit

Interface
REQ-001 Parameter XLEN, default 32: address/PC width.
REQ-002 Parameter BHT_DEPTH, default 64: branch history table entries; power of two, 4 to 1024.
REQ-003 Parameter CNT_W, default 16: statistics counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 pc_if  input  XLEN  fetch-stage PC for prediction lookup.
REQ-007 pred_taken_if  output  1  combinational prediction for pc_if.
REQ-008 valid_in_Mem  input  1  MEM-stage instruction valid.
REQ-009 pc_in_Mem  input  XLEN  PC of the MEM-stage instruction.
REQ-010 target_in_Mem  input  XLEN  computed branch/jump target.
REQ-011 Branch_in_Mem  input  1  conditional branch.
REQ-012 Jump_in_Mem  input  1  JAL/JALR.
REQ-013 funct3_in_Mem  input  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-014 zero_in_Mem, lt_in_Mem, ltu_in_Mem  input  1 each  ALU flags: equal, signed less-than, unsigned less-than.
REQ-015 pred_taken_in_Mem  input  1  prediction carried down the pipe with the instruction.
REQ-016 PCSrc  output  1  registered redirect request.
REQ-017 redirect_pc  output  XLEN  registered redirect address.
REQ-018 flush  output  1  registered squash of IF/ID/EX.
REQ-019 stat_clr  input  1  synchronous clear of statistics.
REQ-020 br_cnt, mis_cnt  output  CNT_W each  resolved control-transfer count and mispredict count.

Function
REQ-021 resolve = valid_in_Mem & (Branch_in_Mem | Jump_in_Mem) & ~flush; at flush=1 the MEM instruction is wrong-path, is ignored entirely, and updates nothing.
REQ-022 taken = Jump_in_Mem | (Branch_in_Mem & cond(funct3_in_Mem)); funct3 010/011 gives cond=0.
REQ-023 mispredict = resolve & (taken != pred_taken_in_Mem).
REQ-024 On mispredict, next edge sets PCSrc=1, flush=1, redirect_pc = taken ? target_in_Mem : pc_in_Mem+4 (modulo 2^XLEN); otherwise PCSrc=0, flush=0, redirect_pc holds.
REQ-025 Latency: one cycle from resolve to PCSrc/flush; each is a one-cycle pulse; back-to-back pulses impossible (REQ-021).
REQ-026 BHT: BHT_DEPTH 2-bit saturating counters, index = pc[log2(BHT_DEPTH)+1:2]; pred_taken_if = counter[1] of pc_if index.
REQ-027 On resolve with Branch_in_Mem=1: counter increments (saturate at 3) if taken, decrements (saturate at 0) if not; jumps do not update the BHT.
REQ-028 Same-index read and update in one cycle: read returns pre-update value (no bypass).
REQ-029 br_cnt increments on every resolve; mis_cnt on every mispredict; both saturate at all-ones, never wrap.
REQ-030 stat_clr=1 zeroes both counters that edge and takes priority over simultaneous increments.

Reset
REQ-031 rst_n=0 asynchronously forces PCSrc=0, flush=0, redirect_pc=0, br_cnt=0, mis_cnt=0, every BHT counter=2'b01 (weakly not-taken).
REQ-032 Reset mid-pulse cancels the pending redirect; first edge after release performs normal evaluation.

Structure
REQ-033 Shared package holds funct3 branch-code constants, counter-state constants (SNT=00, WNT=01, WT=10, ST=11) and the reset counter value.
REQ-034 One sub-module, branch_cond_eval: combinational funct3 + flags -> cond; BHT and counters stay in the top.

Verification
REQ-035 After reset, pc_if=0x100 -> pred_taken_if=0; all outputs zero.
REQ-036 BEQ at pc 0x40, zero=1, pred=0, target 0x80 -> next cycle PCSrc=1, flush=1, redirect_pc=0x80, mis_cnt=1; following cycle PCSrc=0.
REQ-037 BLTU not taken at pc 0x40, ltu=0, pred=1 -> redirect_pc=0x44; valid branch in flush cycle ignored (br_cnt unchanged).
REQ-038 Three taken resolves at pc 0x40 -> counter 01->10->11->11; pred_taken_if=1 for pc 0x40 and for aliasing pc 0x40+4*BHT_DEPTH.
REQ-039 Force br_cnt to 0xFFFF, resolve again -> stays 0xFFFF; stat_clr with simultaneous mispredict -> both 0.
REQ-040 Assert rst_n low in the cycle PCSrc=1 -> PCSrc, flush drop immediately; BHT returns to 01.
